// File: rtl/exe_stage_unit.sv
// Execute stage of the pipelined ARM core.
// Builds the second ALU operand (Val2) from the shifter-operand field, runs
// the ALU, computes the branch target and owns the NZCV status register and
// the EX/MEM pipeline register that feeds the memory stage.
module exe_stage_unit #(
  parameter int DW  = 32,
  parameter int RDW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           freeze,
  input  logic           flush,
  input  logic           s_update_in,
  input  logic           branch_in,
  input  logic           mem_w_en_in,
  input  logic           mem_r_en_in,
  input  logic           wb_en_in,
  input  logic [3:0]     exe_cmd_in,
  input  logic [DW-1:0]  val_rn_in,
  input  logic [DW-1:0]  val_rm_in,
  input  logic [DW-1:0]  pc_in,
  input  logic [23:0]    imm24_in,
  input  logic [RDW-1:0] rd_in,
  input  logic           imm_in,
  input  logic [11:0]    shift_op_in,
  output logic           branch_taken,
  output logic [DW-1:0]  branch_addr,
  output logic [3:0]     status,
  output logic           wb_en,
  output logic           mem_r_en,
  output logic           mem_w_en,
  output logic [DW-1:0]  alu_res,
  output logic [DW-1:0]  st_val,
  output logic [RDW-1:0] rd
);

  // ALU command encodings
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // Shift types in shift_op_in[6:5]
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  logic [DW-1:0]        val2;
  logic [4:0]           shiftAmt;
  logic [4:0]           immRotAmt;
  logic [2*DW-1:0]      immDouble;
  logic [2*DW-1:0]      immRotated;
  logic [2*DW-1:0]      rmRotated;
  logic signed [DW-1:0] rmAsr;

  logic [DW-1:0] aluRes;
  logic [DW:0]   wideSum;
  logic          carryIn;
  logic          carryNext;
  logic          ovfNext;
  logic [3:0]    aluFlags;

  assign shiftAmt  = shift_op_in[11:7];
  assign immRotAmt = {shift_op_in[11:8], 1'b0};
  assign carryIn   = status[1];

  // Rotates are done by shifting a doubled copy and keeping the low half,
  // which makes a rotate by zero fall out naturally as "unchanged".
  assign immDouble  = {{(DW-8){1'b0}}, shift_op_in[7:0], {(DW-8){1'b0}}, shift_op_in[7:0]};
  assign immRotated = immDouble >> immRotAmt;
  assign rmRotated  = {val_rm_in, val_rm_in} >> shiftAmt;
  assign rmAsr      = $signed(val_rm_in) >>> shiftAmt;

  // Branch redirect is resolved here combinationally; a frozen stage must not redirect fetch.
  assign branch_taken = branch_in & ~freeze;
  assign branch_addr  = pc_in + {{(DW-26){imm24_in[23]}}, imm24_in, 2'b00};

  // Val2 generation: memory offset, rotated immediate, or shifted Rm
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    val2 = '0;
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = {{(DW-12){1'b0}}, shift_op_in};
    end else if (imm_in) begin
      val2 = immRotated[DW-1:0];
    end else begin
      case (shift_op_in[6:5])
        SH_LSL:  val2 = val_rm_in << shiftAmt;
        SH_LSR:  val2 = val_rm_in >> shiftAmt;
        SH_ASR:  val2 = rmAsr;
        SH_ROR:  val2 = rmRotated[DW-1:0];
        default: val2 = val_rm_in;
      endcase
    end
  end

  // ALU and next-flag computation; arithmetic is done one bit wider to expose carry/borrow
  always_comb begin
    aluRes    = '0;
    wideSum   = '0;
    carryNext = status[1];
    ovfNext   = status[0];
    case (exe_cmd_in)
      CMD_MOV: aluRes = val2;
      CMD_MVN: aluRes = ~val2;
      CMD_ADD, CMD_ADC: begin
        wideSum   = {1'b0, val_rn_in} + {1'b0, val2}
                  + {{DW{1'b0}}, (exe_cmd_in == CMD_ADC) & carryIn};
        aluRes    = wideSum[DW-1:0];
        carryNext = wideSum[DW];
        ovfNext   = (val_rn_in[DW-1] == val2[DW-1]) && (wideSum[DW-1] != val_rn_in[DW-1]);
      end
      CMD_SUB, CMD_SBC: begin
        wideSum   = {1'b0, val_rn_in} - {1'b0, val2}
                  - {{DW{1'b0}}, (exe_cmd_in == CMD_SBC) & ~carryIn};
        aluRes    = wideSum[DW-1:0];
        carryNext = ~wideSum[DW];
        ovfNext   = (val_rn_in[DW-1] != val2[DW-1]) && (wideSum[DW-1] != val_rn_in[DW-1]);
      end
      CMD_AND: aluRes = val_rn_in & val2;
      CMD_ORR: aluRes = val_rn_in | val2;
      CMD_EOR: aluRes = val_rn_in ^ val2;
      default: aluRes = '0;
    endcase
  end

  assign aluFlags = {aluRes[DW-1], (aluRes == '0), carryNext, ovfNext};

  // NZCV status register: updated only by S-bit instructions that actually advance
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the reset branch clears every state bit of the block; the
    // asynchronous assert is safe because rst_n is released synchronously.
    if (!rst_n) begin
      status <= 4'b0000;
    end else if (s_update_in && !freeze && !flush) begin
      // NOTE: sequential state is always written with <= so every register
      // samples the pre-edge values, independent of statement order.
      status <= aluFlags;
    end
  end

  // EX/MEM pipeline register: flush inserts a bubble, freeze holds, otherwise capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_res  <= '0;
      st_val   <= '0;
      rd       <= '0;
    end else if (flush) begin
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_res  <= '0;
      st_val   <= '0;
      rd       <= '0;
    end else if (!freeze) begin
      wb_en    <= wb_en_in;
      mem_r_en <= mem_r_en_in;
      mem_w_en <= mem_w_en_in;
      alu_res  <= aluRes;
      st_val   <= val_rm_in;
      rd       <= rd_in;
    end
  end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Self-checking bench for exe_stage_unit: a table of hand-derived vectors
// fed through a one-deep scoreboard, plus directed sequences for freeze,
// flush, branch redirect and asynchronous reset.
module tb_exe_stage_unit;

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_MVN = 4'b1001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_ADC = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_SBC = 4'b0101;
  localparam logic [3:0] C_AND = 4'b0110;
  localparam logic [3:0] C_ORR = 4'b0111;
  localparam logic [3:0] C_EOR = 4'b1000;
  localparam logic [3:0] C_BAD = 4'b1111;

  typedef struct {
    logic        s;
    logic        mw;
    logic        mr;
    logic        wb;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] sop;
    logic [3:0]  rdIdx;
    logic [31:0] expRes;
    logic [3:0]  expStatus;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  rdIdx;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  status;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, s_update_in, branch_in;
  logic        mem_w_en_in, mem_r_en_in, wb_en_in, imm_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] val_rn_in, val_rm_in, pc_in;
  logic [23:0] imm24_in;
  logic [3:0]  rd_in;
  logic [11:0] shift_op_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] alu_res, st_val;
  logic [3:0]  rd;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t lastExp;
  vec_t vecs[17];
  vec_t vA, vB, vC, vD, vE;

  exe_stage_unit #(.DW(32), .RDW(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .s_update_in(s_update_in), .branch_in(branch_in),
    .mem_w_en_in(mem_w_en_in), .mem_r_en_in(mem_r_en_in), .wb_en_in(wb_en_in),
    .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .pc_in(pc_in), .imm24_in(imm24_in), .rd_in(rd_in), .imm_in(imm_in),
    .shift_op_in(shift_op_in), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .status(status), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_res(alu_res),
    .st_val(st_val), .rd(rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic s, input logic mw, input logic mr, input logic wb,
                                 input logic [3:0] cmd, input logic [31:0] rn,
                                 input logic [31:0] rm, input logic imm,
                                 input logic [11:0] sop, input logic [3:0] rdIdx,
                                 input logic [31:0] expRes, input logic [3:0] expStatus);
    vec_t v;
    v.s = s; v.mw = mw; v.mr = mr; v.wb = wb; v.cmd = cmd; v.rn = rn; v.rm = rm;
    v.imm = imm; v.sop = sop; v.rdIdx = rdIdx; v.expRes = expRes; v.expStatus = expStatus;
    return v;
  endfunction

  function automatic exp_t expOf(input vec_t v);
    exp_t e;
    e.res = v.expRes; e.st = v.rm; e.rdIdx = v.rdIdx;
    e.wb = v.wb; e.mr = v.mr; e.mw = v.mw; e.status = v.expStatus;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [3:0] st);
    exp_t e;
    e.res = '0; e.st = '0; e.rdIdx = '0; e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.status = st;
    return e;
  endfunction

  task automatic setInputs(input vec_t v);
    s_update_in = v.s; mem_w_en_in = v.mw; mem_r_en_in = v.mr; wb_en_in = v.wb;
    exe_cmd_in = v.cmd; val_rn_in = v.rn; val_rm_in = v.rm; imm_in = v.imm;
    shift_op_in = v.sop; rd_in = v.rdIdx;
  endtask

  task automatic compareOut(input string name, input exp_t e);
    check({name, ".alu_res"},  alu_res,  e.res);
    check({name, ".st_val"},   st_val,   e.st);
    check({name, ".rd"},       {28'b0, rd}, {28'b0, e.rdIdx});
    check({name, ".wb_en"},    {31'b0, wb_en},    {31'b0, e.wb});
    check({name, ".mem_r_en"}, {31'b0, mem_r_en}, {31'b0, e.mr});
    check({name, ".mem_w_en"}, {31'b0, mem_w_en}, {31'b0, e.mw});
    check({name, ".status"},   {28'b0, status},   {28'b0, e.status});
  endtask

  // Advance one clock with inputs already driven, then score the oldest expectation.
  task automatic stepAndScore(input string name);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty when output sampled", name);
    end else begin
      e = q.pop_front();
      compareOut(name, e);
      lastExp = e;
    end
  endtask

  task automatic applyVec(input vec_t v, input string name);
    setInputs(v);
    q.push_back(expOf(v));
    stepAndScore(name);
  endtask

  initial begin
    // Vector table: {S, mw, mr, wb, cmd, Rn, Rm, I, shift_op, Rd, expected result, expected NZCV}
    vecs[0]  = mkVec(1, 0, 0, 1, C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 12'h000, 4'h3, 32'h8000_0000, 4'b1001);
    vecs[1]  = mkVec(1, 0, 0, 1, C_SUB, 32'h0000_0005, 32'hDEAD_BEEF, 1, 12'h005, 4'h4, 32'h0000_0000, 4'b0110);
    vecs[2]  = mkVec(1, 0, 0, 1, C_MOV, 32'h0000_0000, 32'h0000_0000, 1, 12'h1FF, 4'h5, 32'hC000_003F, 4'b1010);
    vecs[3]  = mkVec(1, 0, 0, 1, C_ADC, 32'hFFFF_FFFF, 32'h0000_0000, 1, 12'h000, 4'h6, 32'h0000_0000, 4'b0110);
    vecs[4]  = mkVec(0, 0, 0, 1, C_MOV, 32'h0000_0000, 32'h8000_0000, 0, 12'h240, 4'h7, 32'hF800_0000, 4'b0110);
    vecs[5]  = mkVec(1, 0, 0, 1, C_MOV, 32'h0000_0000, 32'h0000_0003, 0, 12'hF80, 4'h8, 32'h8000_0000, 4'b1010);
    vecs[6]  = mkVec(1, 0, 0, 1, C_ORR, 32'h0000_00F0, 32'hF000_0000, 0, 12'hE20, 4'h9, 32'h0000_00FF, 4'b0010);
    vecs[7]  = mkVec(0, 0, 0, 1, C_EOR, 32'h0000_0000, 32'h0000_0001, 0, 12'h0E0, 4'hA, 32'h8000_0000, 4'b0010);
    vecs[8]  = mkVec(1, 0, 0, 1, C_SBC, 32'h0000_0000, 32'h0000_0000, 1, 12'h001, 4'hB, 32'hFFFF_FFFF, 4'b1000);
    vecs[9]  = mkVec(1, 0, 0, 1, C_SBC, 32'h0000_000A, 32'h0000_0000, 1, 12'h003, 4'hC, 32'h0000_0006, 4'b0010);
    vecs[10] = mkVec(1, 0, 0, 1, C_SUB, 32'h8000_0000, 32'h0000_0000, 1, 12'h001, 4'hD, 32'h7FFF_FFFF, 4'b0011);
    vecs[11] = mkVec(1, 0, 0, 1, C_MVN, 32'h0000_0000, 32'h0000_0000, 1, 12'h000, 4'hE, 32'hFFFF_FFFF, 4'b1011);
    vecs[12] = mkVec(1, 0, 0, 0, C_BAD, 32'h1234_5678, 32'h0000_0000, 0, 12'h000, 4'hF, 32'h0000_0000, 4'b0111);
    vecs[13] = mkVec(1, 0, 0, 1, C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 12'h000, 4'h1, 32'hF000_F000, 4'b1011);
    vecs[14] = mkVec(0, 1, 0, 0, C_ADD, 32'h0000_1000, 32'hCAFE_F00D, 1, 12'hFFF, 4'h7, 32'h0000_1FFF, 4'b1011);
    vecs[15] = mkVec(0, 0, 1, 1, C_ADD, 32'h0000_2000, 32'h1234_5678, 0, 12'h004, 4'h2, 32'h0000_2004, 4'b1011);
    vecs[16] = mkVec(0, 0, 0, 1, C_ADC, 32'h0000_0001, 32'h0000_0002, 0, 12'h000, 4'h3, 32'h0000_0004, 4'b1011);

    vA = mkVec(1, 0, 0, 1, C_ADD, 32'h0000_0001, 32'h0000_0001, 0, 12'h000, 4'h5, 32'h0000_0002, 4'b0000);
    vB = mkVec(1, 0, 0, 1, C_MVN, 32'h0000_0000, 32'h0000_0055, 1, 12'h000, 4'h6, 32'hFFFF_FFFF, 4'b1000);
    vC = mkVec(1, 0, 0, 1, C_MOV, 32'h0000_0000, 32'h0000_0000, 1, 12'h005, 4'h1, 32'h0000_0005, 4'b0000);
    vD = mkVec(1, 0, 0, 0, C_MOV, 32'h0000_0000, 32'h0000_0000, 1, 12'h000, 4'h0, 32'h0000_0000, 4'b0100);
    vE = mkVec(0, 0, 0, 1, C_MOV, 32'h0000_0000, 32'h0000_0000, 1, 12'h005, 4'h1, 32'h0000_0005, 4'b0100);

    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; branch_in = 1'b0;
    pc_in = '0; imm24_in = '0;
    setInputs(mkVec(0, 0, 0, 0, 4'h0, '0, '0, 0, 12'h000, 4'h0, '0, 4'h0));
    @(negedge clk);
    @(negedge clk);
    compareOut("reset", bubble(4'b0000));
    rst_n = 1'b1;

    // Table-driven ALU / shifter / flag vectors
    for (int i = 0; i < 17; i++) begin
      applyVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Freeze for two cycles: EX/MEM and status hold; no branch redirect while frozen
    freeze = 1'b1;
    branch_in = 1'b1;
    setInputs(vA);
    #1;
    check("freeze.branch_taken", {31'b0, branch_taken}, 32'h0);
    branch_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q.push_back(lastExp);
      stepAndScore($sformatf("freeze%0d", i));
    end
    freeze = 1'b0;
    applyVec(vA, "unfreeze");

    // Flush and freeze together with S=1: bubble wins, status untouched
    freeze = 1'b1;
    flush  = 1'b1;
    setInputs(vB);
    q.push_back(bubble(lastExp.status));
    stepAndScore("flush_freeze");
    freeze = 1'b0;
    flush  = 1'b0;
    applyVec(vB, "after_flush");

    // Flush alone with S=1
    flush = 1'b1;
    setInputs(vC);
    q.push_back(bubble(lastExp.status));
    stepAndScore("flush");
    flush = 1'b0;

    // Taken branch: combinational target, and S=1 still updates status
    branch_in = 1'b1;
    pc_in     = 32'h0000_0100;
    imm24_in  = 24'hFFFFFE;
    setInputs(vD);
    #1;
    check("branch.taken", {31'b0, branch_taken}, 32'h1);
    check("branch.addr_back", branch_addr, 32'h0000_00F8);
    q.push_back(expOf(vD));
    stepAndScore("branch_s");
    pc_in    = 32'h0000_0200;
    imm24_in = 24'h000003;
    #1;
    check("branch.addr_fwd", branch_addr, 32'h0000_020C);
    branch_in = 1'b0;
    #1;
    check("branch.not_taken", {31'b0, branch_taken}, 32'h0);
    @(negedge clk);

    // Asynchronous reset between clock edges with a live EX/MEM entry
    applyVec(vE, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    compareOut("async_reset", bubble(4'b0000));
    @(negedge clk);
    compareOut("held_reset", bubble(4'b0000));
    rst_n = 1'b1;
    applyVec(vecs[0], "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
